// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and counter-width helper for seq_multiplier_n
package mult_pkg;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;
  localparam int DEFAULT_WIDTH = 8;
  // Counter must index 0..w-1; keep at least one bit for w=2.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: N-bit ripple-carry adder
//   A, B : addends (N bits)   c_in : carry in
//   Sum  : N-bit sum          CO   : carry out
module ripple_adder_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] Sum,
  output logic         CO
);
  logic [N:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign CO = c[N];
endmodule

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: shift-add WIDTHxWIDTH multiplier, signed or unsigned, Start/Busy/Done handshake
//   Clk, Reset (sync, active-low), Start, Signed_Mode
//   Multiplicand (S), Multiplier (B) : WIDTH-bit operands, latched with Start
//   Busy : operation in flight        Done : one-cycle result-valid pulse
//   Product : 2*WIDTH-bit registered result   X : extension/carry bit of {X,A,B}
module seq_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 X
);
  mult_state_t      state;
  logic [WIDTH-1:0] s, a, b;
  logic             sgn;
  logic [CNT_W-1:0] count;
  logic             last, neg, co_unused;
  logic [WIDTH:0]   ext_s, op, sum;
  // Last signed iteration subtracts: ~ext(S) here plus c_in=1 on the same adder.
  always_comb begin
    last  = count == CNT_W'(WIDTH - 1);
    neg   = sgn & last & b[0];
    ext_s = {sgn & s[WIDTH-1], s};
    op    = b[0] ? (neg ? ~ext_s : ext_s) : '0;
  end
  ripple_adder_n #(.N(WIDTH + 1)) u_add (
    .A    ({sgn & a[WIDTH-1], a}),
    .B    (op),
    .c_in (neg),
    .Sum  (sum),
    .CO   (co_unused)
  );
  // Busy is registered, so it stays high through the Done cycle and drops
  // on the edge after, while the FSM is already back in IDLE accepting Start.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      s       <= '0;
      a       <= '0;
      b       <= '0;
      sgn     <= 1'b0;
      X       <= 1'b0;
      count   <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          Busy <= Start;
          if (Start) begin
            s     <= Multiplicand;
            b     <= Multiplier;
            sgn   <= Signed_Mode;
            a     <= '0;
            X     <= 1'b0;
            count <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          {X, a} <= sum;
          state  <= SHIFT;
        end
        SHIFT: begin
          X     <= sgn & X;
          a     <= {X, a[WIDTH-1:1]};
          b     <= {a[0], b[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          state <= last ? DONE : ADD;
        end
        DONE: begin
          Product <= {a, b};
          Done    <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb_seq_multiplier_n: directed and reference-checked bench for seq_multiplier_n at WIDTH 8, 4, 2, 16
module tb_seq_multiplier_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sm = 1'b0;
  logic [15:0] s_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  start_v = '0;
  logic [3:0]  busy_v, done_v, x_v;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic [3:0]  p2;
  logic [31:0] p16;
  logic [31:0] p_v [4];
  int          pulses [4];
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign p_v[0] = 32'(p8);
  assign p_v[1] = 32'(p4);
  assign p_v[2] = 32'(p2);
  assign p_v[3] = p16;

  seq_multiplier_n #(.WIDTH(8)) u8 (
    .Clk(clk), .Reset(rst_n), .Start(start_v[0]), .Signed_Mode(sm),
    .Multiplicand(s_in[7:0]), .Multiplier(b_in[7:0]),
    .Busy(busy_v[0]), .Done(done_v[0]), .Product(p8), .X(x_v[0]));
  seq_multiplier_n #(.WIDTH(4)) u4 (
    .Clk(clk), .Reset(rst_n), .Start(start_v[1]), .Signed_Mode(sm),
    .Multiplicand(s_in[3:0]), .Multiplier(b_in[3:0]),
    .Busy(busy_v[1]), .Done(done_v[1]), .Product(p4), .X(x_v[1]));
  seq_multiplier_n #(.WIDTH(2)) u2 (
    .Clk(clk), .Reset(rst_n), .Start(start_v[2]), .Signed_Mode(sm),
    .Multiplicand(s_in[1:0]), .Multiplier(b_in[1:0]),
    .Busy(busy_v[2]), .Done(done_v[2]), .Product(p2), .X(x_v[2]));
  seq_multiplier_n #(.WIDTH(16)) u16 (
    .Clk(clk), .Reset(rst_n), .Start(start_v[3]), .Signed_Mode(sm),
    .Multiplicand(s_in), .Multiplier(b_in),
    .Busy(busy_v[3]), .Done(done_v[3]), .Product(p16), .X(x_v[3]));

  initial for (int i = 0; i < 4; i++) pulses[i] = 0;
  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (done_v[i] === 1'b1) pulses[i]++;

  function automatic logic [31:0] ref_prod(input int w, input bit sgn, input logic [15:0] s, input logic [15:0] b);
    longint m, sv, bv;
    m  = (longint'(1) << w) - 1;
    sv = longint'(s) & m;
    bv = longint'(b) & m;
    if (sgn && sv[w-1]) sv -= longint'(1) << w;
    if (sgn && bv[w-1]) bv -= longint'(1) << w;
    return 32'((sv * bv) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (done_v[i] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input int i, input int w, input bit sgn, input logic [15:0] s, input logic [15:0] b,
                     input logic [31:0] exp, input string name);
    int n;
    @(negedge clk);
    sm = sgn; s_in = s; b_in = b; start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    checks++;
    if (busy_v[i] !== 1'b1) begin errs++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_v[i]); end
    wait_done(i, n);
    checks++;
    if (n != 2 * w + 1) begin errs++; $display("FAIL %s latency: got %0d want %0d", name, n, 2 * w + 1); end
    checks++;
    if (p_v[i] !== exp) begin errs++; $display("FAIL %s product: got %h want %h", name, p_v[i], exp); end
    @(posedge clk); #1;
    checks++;
    if (done_v[i] !== 1'b0 || busy_v[i] !== 1'b0)
      begin errs++; $display("FAIL %s done_busy_after: got done=%b busy=%b want 0 0", name, done_v[i], busy_v[i]); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || p_v[i] !== 32'h0 || x_v[i] !== 1'b0)
        begin errs++; $display("FAIL reset_state[%0d]: got busy=%b done=%b p=%h x=%b want 0 0 0 0", i, busy_v[i], done_v[i], p_v[i], x_v[i]); end
    end
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_v[0] !== 1'b0) begin errs++; $display("FAIL reset_beats_start: got busy=%b want 0", busy_v[0]); end
    @(negedge clk);
    start_v[0] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_signed8;
    run(0, 8, 1'b1, 16'h0007, 16'h00FD, 32'h0000FFEB, "s8_7x-3");
    run(0, 8, 1'b1, 16'h0080, 16'h0080, 32'h00004000, "s8_-128x-128");
  endtask

  task automatic test_unsigned8;
    run(0, 8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, "u8_ffxff");
    run(0, 8, 1'b1, 16'h00FF, 16'h00FF, 32'h00000001, "s8_-1x-1");
  endtask

  task automatic test_widths;
    run(1, 4, 1'b1, 16'h0008, 16'h0007, 32'h000000C8, "s4_-8x7");
    run(2, 2, 1'b1, 16'h0002, 16'h0002, 32'h00000004, "s2_-2x-2");
    run(2, 2, 1'b0, 16'h0003, 16'h0003, 32'h00000009, "u2_3x3");
    run(3, 16, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "s16_min_x_min");
    run(3, 16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u16_max_x_max");
  endtask

  task automatic test_ignore_start;
    int p0, n;
    p0 = pulses[0];
    @(negedge clk);
    sm = 1'b0; s_in = 16'h0012; b_in = 16'h0034; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_v[0] = (c >= 3);
      if (c >= 3) begin sm = c[0]; s_in = 16'($urandom); b_in = 16'($urandom); end
    end
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, n);
    checks++;
    if (p_v[0] !== 32'h000003A8) begin errs++; $display("FAIL ignore_start_product: got %h want 000003a8", p_v[0]); end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (pulses[0] - p0 != 1) begin errs++; $display("FAIL ignore_start_pulses: got %0d want 1", pulses[0] - p0); end
    checks++;
    if (busy_v[0] !== 1'b0) begin errs++; $display("FAIL ignore_start_idle: got busy=%b want 0", busy_v[0]); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    sm = 1'b1; s_in = 16'h0005; b_in = 16'h00FD; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, n);
    checks++;
    if (p_v[0] !== 32'h0000FFF1) begin errs++; $display("FAIL b2b_first_product: got %h want 0000fff1", p_v[0]); end
    sm = 1'b0; s_in = 16'h0003; b_in = 16'h0004; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0)
      begin errs++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy_v[0], done_v[0]); end
    wait_done(0, n);
    checks++;
    if (n != 17) begin errs++; $display("FAIL b2b_latency: got %0d want 17", n); end
    checks++;
    if (p_v[0] !== 32'h0000000C) begin errs++; $display("FAIL b2b_second_product: got %h want 0000000c", p_v[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int p0;
    @(negedge clk);
    sm = 1'b0; s_in = 16'h0012; b_in = 16'h0034; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    p0 = pulses[0];
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || p_v[0] !== 32'h0)
      begin errs++; $display("FAIL abort_state: got busy=%b done=%b p=%h want 0 0 0", busy_v[0], done_v[0], p_v[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (pulses[0] != p0) begin errs++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses[0] - p0); end
  endtask

  task automatic test_random;
    int idx [3] = '{0, 2, 3};
    int wid [3] = '{8, 2, 16};
    logic [15:0] s, b;
    bit sgn;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 6; j++) begin
        s = 16'($urandom);
        b = 16'($urandom);
        sgn = j[0];
        run(idx[k], wid[k], sgn, s, b, ref_prod(wid[k], sgn, s, b), $sformatf("rand_w%0d_%0d", wid[k], j));
      end
  endtask

  initial begin
    test_reset;
    test_signed8;
    test_unsigned8;
    test_widths;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
